// File: rtl/video_timing_pkg.sv
// Shared timing presets, FSM state type and colour-bar lookup for video_timing_gen.
package video_timing_pkg;

  // 1280x720 @ 60 Hz
  localparam int unsigned T720_H_SYNC  = 40;
  localparam int unsigned T720_H_BACK  = 220;
  localparam int unsigned T720_H_DISP  = 1280;
  localparam int unsigned T720_H_FRONT = 110;
  localparam int unsigned T720_V_SYNC  = 5;
  localparam int unsigned T720_V_BACK  = 20;
  localparam int unsigned T720_V_DISP  = 720;
  localparam int unsigned T720_V_FRONT = 5;

  // 1920x1080 @ 60 Hz
  localparam int unsigned T1080_H_SYNC  = 44;
  localparam int unsigned T1080_H_BACK  = 148;
  localparam int unsigned T1080_H_DISP  = 1920;
  localparam int unsigned T1080_H_FRONT = 88;
  localparam int unsigned T1080_V_SYNC  = 5;
  localparam int unsigned T1080_V_BACK  = 36;
  localparam int unsigned T1080_V_DISP  = 1080;
  localparam int unsigned T1080_V_FRONT = 4;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} vtg_state_e;

  // White, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vtg_delay.sv
// Fixed-depth shift register used to align timing strobes with the pixel pipeline.
module vtg_delay #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             pixel_clk,
  input  logic             sys_rst,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o
);

  logic [Width-1:0] pipe_q [Depth];

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[Depth-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with pixel request lead; define VTG_TEST_PATTERN_EN to add
// the pattern_sel input and an internal 8-bar colour pattern.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BACK   = 220,
  parameter int unsigned H_DISP   = 1280,
  parameter int unsigned H_FRONT  = 110,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACK   = 20,
  parameter int unsigned V_DISP   = 720,
  parameter int unsigned V_FRONT  = 5,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned REQ_LEAD = 1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             pixel_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic [23:0]      pixel_data,
`ifdef VTG_TEST_PATTERN_EN
  input  logic             pattern_sel,
`endif
  output logic             data_req,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_de,
  output logic [23:0]      video_rgb,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  if (REQ_LEAD < 1 || REQ_LEAD > 4 || H_SYNC == 0 || H_BACK == 0 || H_DISP == 0 ||
      H_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 || V_DISP == 0 || V_FRONT == 0 ||
      64'(H_TOTAL) > (64'd1 << CNT_W) - 64'd1 ||
      64'(V_TOTAL) > (64'd1 << CNT_W) - 64'd1) begin : g_bad_params
    $error("video_timing_gen: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] HMax   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VMax   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HSyncE = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VSyncE = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HActS  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] HActE  = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] VActS  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] VActE  = CNT_W'(V_SYNC + V_BACK + V_DISP);

  vtg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  logic [CNT_W-1:0] xpos_q, ypos_q;
  logic             req_q, req_d, last;
  logic [23:0]      rgb_q, rgb_d;

  assign last = (cnt_h_q == HMax) && (cnt_v_q == VMax);

  always_comb begin
    state_d = state_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StDrain;
      StDrain: begin
        if (en)        state_d = StRun;
        else if (last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_q == StIdle) begin
      cnt_h_d = '0;
      cnt_v_d = '0;
    end else if (cnt_h_q == HMax) begin
      cnt_h_d = '0;
      cnt_v_d = (cnt_v_q == VMax) ? '0 : cnt_v_q + CNT_W'(1);
    end else begin
      cnt_h_d = cnt_h_q + CNT_W'(1);
    end
  end

  // Request is decoded from the next position so it lines up with the live counters.
  assign req_d = (state_d != StIdle) && (cnt_h_d >= HActS) && (cnt_h_d < HActE) &&
                 (cnt_v_d >= VActS) && (cnt_v_d < VActE);

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      req_q   <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      req_q   <= req_d;
      xpos_q  <= req_d ? cnt_h_d - HActS : '0;
      ypos_q  <= req_d ? cnt_v_d - VActS : '0;
      rgb_q   <= rgb_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign data_req   = req_q;
  assign pixel_xpos = xpos_q;
  assign pixel_ypos = ypos_q;

  logic [3:0] sync_din, sync_dout;
  assign sync_din = {busy && (cnt_h_q == '0) && (cnt_v_q == '0), req_q,
                     busy && (cnt_v_q < VSyncE), busy && (cnt_h_q < HSyncE)};

  vtg_delay #(.Width(4), .Depth(REQ_LEAD)) u_sync_dly (
    .pixel_clk(pixel_clk),
    .sys_rst  (sys_rst),
    .din_i    (sync_din),
    .dout_o   (sync_dout)
  );

  assign video_hs    = sync_dout[0] ^ ~HS_POL;
  assign video_vs    = sync_dout[1] ^ ~VS_POL;
  assign video_de    = sync_dout[2];
  assign frame_start = sync_dout[3];

`ifdef VTG_TEST_PATTERN_EN
  localparam int unsigned DataW = 4;
  localparam logic [CNT_W-1:0] BarW = CNT_W'((H_DISP >= 8) ? H_DISP / 8 : 1);
  localparam logic [CNT_W-1:0] Bar7 = CNT_W'(7 * ((H_DISP >= 8) ? H_DISP / 8 : 1));
  logic [2:0] bar_idx, bar_pre;
  assign bar_idx = (xpos_q >= Bar7) ? 3'd7 : 3'(xpos_q / BarW);
`else
  localparam int unsigned DataW = 1;
`endif

  // Data-path strobe runs one stage short so video_rgb registers in step with video_de.
  logic [DataW-1:0] data_din, data_pre;
  logic             de_pre;
`ifdef VTG_TEST_PATTERN_EN
  assign data_din = {bar_idx, req_q};
  assign bar_pre  = data_pre[3:1];
`else
  assign data_din = req_q;
`endif
  assign de_pre = data_pre[0];

  if (REQ_LEAD == 1) begin : g_no_data_dly
    assign data_pre = data_din;
  end else begin : g_data_dly
    vtg_delay #(.Width(DataW), .Depth(REQ_LEAD - 1)) u_data_dly (
      .pixel_clk(pixel_clk),
      .sys_rst  (sys_rst),
      .din_i    (data_din),
      .dout_o   (data_pre)
    );
  end

  always_comb begin
    rgb_d = '0;
    if (de_pre) begin
      rgb_d = pixel_data;
`ifdef VTG_TEST_PATTERN_EN
      if (pattern_sel) rgb_d = bar_color(bar_pre);
`endif
    end
  end

  assign video_rgb = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 15x8 raster with REQ_LEAD=3 and positive syncs.
module tb_video_timing_gen;

  localparam int unsigned CntW = 12;
  localparam int          Lead = 3;
  localparam logic [23:0] Bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic            pixel_clk = 1'b0;
  logic            sys_rst, en;
  logic [23:0]     pixel_data;
  logic            pattern_sel;
  logic            data_req, video_hs, video_vs, video_de, frame_start, busy;
  logic [CntW-1:0] pixel_xpos, pixel_ypos;
  logic [23:0]     video_rgb;

  int              n_checks = 0;
  int              n_pass = 0;
  logic            req_h [2];
  logic [CntW-1:0] x_h [2];

  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(Lead), .CNT_W(CntW)
  ) dut (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .pixel_data (pixel_data),
`ifdef VTG_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .data_req   (data_req),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .video_hs   (video_hs),
    .video_vs   (video_vs),
    .video_de   (video_de),
    .video_rgb  (video_rgb),
    .frame_start(frame_start),
    .busy       (busy)
  );

  task automatic check(input string tag, input int n, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s@%0d: got %0h expected %0h", tag, n, got, exp);
  endtask

  function automatic logic [23:0] ramp(input int x);
    return 24'h102030 + 24'(x) * 24'h010101;
  endfunction

  function automatic bit act_pos(input int p);
    int h, v;
    h = p % 15;
    v = (p / 15) % 8;
    return (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
  endfunction

  // Advance to the next falling edge and play the pixel source: data for a request
  // seen two cycles ago, junk otherwise.
  task automatic tick();
    @(negedge pixel_clk);
    pixel_data = req_h[1] ? ramp(int'(x_h[1])) : 24'h5A5A5A;
    req_h[1]   = req_h[0];
    x_h[1]     = x_h[0];
    req_h[0]   = data_req;
    x_h[0]     = pixel_xpos;
  endtask

  // n counts cycles from the first RUN cycle; run_end is the first idle cycle.
  task automatic check_cycle(input int n, input int run_end, input bit pat);
    int m, x, y, xm;
    bit run, ereq, val, ede;
    logic [23:0] ergb;
    m    = n - Lead;
    run  = n < run_end;
    ereq = run && act_pos(n);
    x    = ereq ? n % 15 - 5 : 0;
    y    = ereq ? (n / 15) % 8 - 3 : 0;
    val  = (m >= 0) && (m < run_end);
    ede  = val && act_pos(m);
    ergb = '0;
    if (ede) begin
      xm   = m % 15 - 5;
      ergb = pat ? Bars[xm] : ramp(xm);
    end
    check("busy", n, 32'(busy), 32'(run));
    check("data_req", n, 32'(data_req), 32'(ereq));
    check("xpos", n, 32'(pixel_xpos), 32'(x));
    check("ypos", n, 32'(pixel_ypos), 32'(y));
    check("hs", n, 32'(video_hs), 32'(val && (m % 15 < 2)));
    check("vs", n, 32'(video_vs), 32'(val && ((m / 15) % 8 < 1)));
    check("de", n, 32'(video_de), 32'(ede));
    check("frame_start", n, 32'(frame_start), 32'(val && (m % 120 == 0)));
    check("rgb", n, 32'(video_rgb), 32'(ergb));
  endtask

  // Positive-polarity syncs make every idle output 0.
  task automatic check_idle(input string tag, input int n);
    check({tag, "_busy"}, n, 32'(busy), 32'd0);
    check({tag, "_req"}, n, 32'(data_req), 32'd0);
    check({tag, "_xpos"}, n, 32'(pixel_xpos), 32'd0);
    check({tag, "_hs"}, n, 32'(video_hs), 32'd0);
    check({tag, "_vs"}, n, 32'(video_vs), 32'd0);
    check({tag, "_de"}, n, 32'(video_de), 32'd0);
    check({tag, "_fs"}, n, 32'(frame_start), 32'd0);
    check({tag, "_rgb"}, n, 32'(video_rgb), 32'd0);
  endtask

  initial begin
    sys_rst     = 1'b1;
    en          = 1'b0;
    pattern_sel = 1'b0;
    pixel_data  = '0;
    req_h       = '{1'b0, 1'b0};
    x_h         = '{'0, '0};
    repeat (3) tick();
    check_idle("reset", 0);
    sys_rst = 1'b0;
    repeat (4) tick();
    check_idle("post_rst", 0);

    // Continuous run: drain/resume in frame 1, final drain from frame 2 ending at 360.
    en = 1'b1;
    tick();
    for (int n = 0; n < 370; n++) begin
      check_cycle(n, 360, 1'b0);
      if (n == 150) en = 1'b0;
      if (n == 170) en = 1'b1;
      if (n == 270) en = 1'b0;
      tick();
    end
    check_idle("drained", 370);

    // Asynchronous reset in the middle of an active line.
    en = 1'b1;
    tick();
    for (int n = 0; n < 55; n++) begin
      check_cycle(n, 1 << 30, 1'b0);
      tick();
    end
    check("de_before_rst", 55, 32'(video_de), 32'd1);
    #2 sys_rst = 1'b1;
    #1 check_idle("rst_mid", 55);
    en = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      check_idle("after_rst", n);
    end

`ifdef VTG_TEST_PATTERN_EN
    pattern_sel = 1'b1;
    en          = 1'b1;
    tick();
    for (int n = 0; n < 126; n++) begin
      check_cycle(n, 120, 1'b1);
      if (n == 10) en = 1'b0;
      tick();
    end
    check_idle("pattern_done", 126);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL expose parameter H_SYNC, default 40, horizontal sync width in pixel clocks.
REQ-002 The block SHALL expose parameter H_BACK, default 220, horizontal back porch.
REQ-003 The block SHALL expose parameter H_DISP, default 1280, active pixels per line.
REQ-004 The block SHALL expose parameter H_FRONT, default 110, horizontal front porch.
REQ-005 The block SHALL expose parameters V_SYNC / V_BACK / V_DISP / V_FRONT, defaults 5 / 20 / 720 / 5, vertical equivalents in lines.
REQ-006 The block SHALL expose parameter HS_POL and parameter VS_POL, default 0 each, sync active level (0 = active-low).
REQ-007 The block SHALL expose parameter REQ_LEAD, default 1, range 1..4, cycles from pixel request to video_de.
REQ-008 The block SHALL expose parameter CNT_W, default 12, counter and coordinate width.
REQ-009 The block SHALL have ports: pixel_clk in 1 clock; sys_rst in 1 asynchronous active-high reset; en in 1 run request; pixel_data in 24 RGB888 from source; data_req out 1 pixel request; pixel_xpos out CNT_W; pixel_ypos out CNT_W; video_hs out 1; video_vs out 1; video_de out 1; video_rgb out 24; frame_start out 1 one-cycle pulse; busy out 1 high outside IDLE.

Function
REQ-010 The block SHALL compute H_TOTAL/V_TOTAL as the sums of the four segments; cnt_h counts 0..H_TOTAL-1 and cnt_v increments on cnt_h wrap, wrapping 0..V_TOTAL-1; segment order is sync, back, active, front.
REQ-011 The block SHALL implement FSM IDLE -> RUN on en=1 (counters at 0 in first RUN cycle); RUN -> DRAIN on en=0; DRAIN -> RUN on en=1 without counter disturbance; DRAIN -> IDLE at last cycle of frame (cnt_h=H_TOTAL-1, cnt_v=V_TOTAL-1).
REQ-012 In IDLE the block SHALL hold counters at 0, drive sync outputs at inactive level, data_req/video_de/frame_start at 0, video_rgb at 0.
REQ-013 The block SHALL register video_hs/video_vs/video_de, asserting them REQ_LEAD cycles after the counter position that defines them.
REQ-014 The block SHALL assert data_req, registered, for exactly H_DISP consecutive cycles per active line, REQ_LEAD cycles before the matching video_de cycles.
REQ-015 pixel_xpos/pixel_ypos SHALL be 0-based active coordinates valid while data_req=1, and 0 otherwise.
REQ-016 The source SHALL present pixel_data REQ_LEAD-1 cycles after the request; the block SHALL register video_rgb = pixel_data when aligned video_de=1, else 0.
REQ-017 The block SHALL pulse frame_start for one cycle coincident with the first video_vs assertion of each frame.
REQ-018 The block SHALL fail elaboration when REQ_LEAD is outside 1..4, any segment is 0, or H_TOTAL/V_TOTAL exceed 2**CNT_W-1.

Reset
REQ-019 Asserting sys_rst SHALL immediately force IDLE, counters 0, video_hs=~HS_POL, video_vs=~VS_POL, all other outputs 0, and flush alignment pipelines, including mid-line.
REQ-020 After sys_rst release the block SHALL remain in IDLE until en=1 is sampled.

Configuration
REQ-021 With VTG_TEST_PATTERN_EN defined, the block SHALL add input pattern_sel (1 bit); when 1, video_rgb SHALL show 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), each H_DISP/8 pixels wide, with the last bar absorbing the remainder; data_req SHALL still be driven.
REQ-022 Without VTG_TEST_PATTERN_EN, port pattern_sel and the bar logic SHALL be absent and video_rgb SHALL always follow REQ-016.

Structure
REQ-023 Package video_timing_pkg SHALL hold the 720p60 and 1080p60 timing constants and the FSM state enum (IDLE, RUN, DRAIN).
REQ-024 Sub-module vtg_delay (parametric-depth shift register) SHALL implement the REQ_LEAD alignment of hs/vs/de/frame_start.

Verification (bench timing H 2/3/8/2 total 15, V 1/2/4/1 total 8)
REQ-025 Reset, then en=1 -> busy=1 next cycle; first data_req at cnt_h=5, cnt_v=3; video_de REQ_LEAD cycles later; 8 de cycles per line; 4 lines per frame.
REQ-026 REQ_LEAD=3, pixel_data=xpos-derived ramp -> video_rgb equals ramp value for xpos 0..7 in order; video_rgb=0 outside de.
REQ-027 en=0 mid-frame -> frame completes (120 cycles total); IDLE next cycle; en=1 during DRAIN -> no frame gap, frame_start every 120 cycles.
REQ-028 HS_POL=1, VS_POL=1 -> hs high 2 cycles per line, vs high 1 line per frame; reset levels 0.
REQ-029 sys_rst pulse during active line -> all outputs inactive in the same cycle; no residual de after release.
REQ-030 VTG_TEST_PATTERN_EN defined, pattern_sel=1, H_DISP=8 -> video_rgb sequence FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
